// File: rtl/gv_button_conditioner_pkg.sv
// Shared constants for the Guitar Villains button conditioner.
// Cycle counts are derived from the 10 MHz system clock.
package gv_pkg;

  localparam int NUM_BTN_DEF         = 4;
  localparam int CLK_HZ              = 10_000_000;
  localparam int DEBOUNCE_MS         = 10;
  localparam int HOLD_MS             = 500;
  localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int HOLD_CYCLES_DEF     = (CLK_HZ / 1000) * HOLD_MS;

  typedef logic [NUM_BTN_DEF-1:0] btn_vec_t;

  // Index width that stays legal when only one button is conditioned.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gv_button_conditioner_if.sv
// Button-path bundle between the raw GPIO pins and the game core.
// The slave modport is the conditioner; the master modport is the pin/core side.
interface gv_button_conditioner_if
  import gv_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEF,
  parameter int IDX_W   = idx_width(NUM_BTN)
) ();

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic               press_valid;
  logic [IDX_W-1:0]   press_idx;
  logic [NUM_BTN-1:0] btn_hold;

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, press_valid, press_idx, btn_hold
  );

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, press_valid, press_idx, btn_hold
  );

endinterface

// File: rtl/gv_button_conditioner_debounce_bit.sv
// Single-button path: 2-flop synchronizer, consecutive-mismatch debounce
// counter, stable level and registered press/release strobes.
module gv_debounce_bit
  import gv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_r;
  logic             s2_r;
  logic             q_r;
  logic [CNT_W-1:0] cnt_r;
  logic             press_r;
  logic             rel_r;

  // Synchronize, count consecutive mismatches, accept the new level and strobe.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      q_r     <= 1'b0;
      cnt_r   <= '0;
      press_r <= 1'b0;
      rel_r   <= 1'b0;
    end else begin
      s1_r    <= raw;
      s2_r    <= s1_r;
      press_r <= 1'b0;
      rel_r   <= 1'b0;
      if (s2_r == q_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
        // Strobes land on the same edge as the level change.
        q_r     <= s2_r;
        cnt_r   <= '0;
        press_r <= s2_r;
        rel_r   <= ~s2_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign level = q_r;
  assign press = press_r;
  assign rel   = rel_r;

endmodule

// File: rtl/gv_button_conditioner.sv
// Fret-button conditioner: per-button debounce, chord-aware press encoder and
// optional long-press detection enabled by defining GV_BTN_HOLD_EN.
module gv_button_conditioner
  import gv_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
  input logic                    clk,
  input logic                    n_rst,
  gv_button_conditioner_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_BTN);

  logic [NUM_BTN-1:0] level_s;
  logic [NUM_BTN-1:0] press_s;
  logic [NUM_BTN-1:0] release_s;
  logic [NUM_BTN-1:0] hold_s;
  logic [IDX_W-1:0]   idx_s;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    gv_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk   (clk),
      .n_rst (n_rst),
      .raw   (bus.btn_raw[i]),
      .level (level_s[i]),
      .press (press_s[i]),
      .rel   (release_s[i])
    );
  end

  // Lowest-numbered pressed button wins; scan from the top so it is written last.
  always_comb begin
    idx_s = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (press_s[i]) begin
        idx_s = IDX_W'(i);
      end else begin
        idx_s = idx_s;
      end
    end
  end

`ifdef GV_BTN_HOLD_EN
  localparam int              HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] hcnt_r [NUM_BTN];

  // Per-button hold counter, cleared while released, saturating at HOLD_CYCLES.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BTN; i++) begin
      if (!n_rst) begin
        hcnt_r[i] <= '0;
      end else if (!level_s[i]) begin
        hcnt_r[i] <= '0;
      end else if (hcnt_r[i] != HOLD_MAX) begin
        hcnt_r[i] <= hcnt_r[i] + HOLD_W'(1);
      end else begin
        hcnt_r[i] <= hcnt_r[i];
      end
    end
  end

  // Gating with the level drops hold on the very cycle the level falls.
  always_comb begin
    hold_s = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      hold_s[i] = level_s[i] && (hcnt_r[i] == HOLD_MAX);
    end
  end
`else
  assign hold_s = '0;
`endif

  assign bus.btn_level   = level_s;
  assign bus.btn_press   = press_s;
  assign bus.btn_release = release_s;
  assign bus.press_valid = |press_s;
  assign bus.press_idx   = idx_s;
  assign bus.btn_hold    = hold_s;

endmodule

// File: tb/tb_gv_button_conditioner.sv
// Directed bench for gv_button_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
// Table-driven vectors plus hand sequences for bounce, mid-debounce reset and hold.
module tb_gv_button_conditioner;

  typedef struct {
    logic             n_rst;
    gv_pkg::btn_vec_t raw;
    gv_pkg::btn_vec_t lvl;
    gv_pkg::btn_vec_t prs;
    gv_pkg::btn_vec_t rel;
    logic             vld;
    logic [1:0]       idx;
  } vec_t;

`ifdef GV_BTN_HOLD_EN
  localparam logic [3:0] HOLD_BIT = 4'h8;
`else
  localparam logic [3:0] HOLD_BIT = 4'h0;
`endif

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  gv_button_conditioner_if #(.NUM_BTN(4)) bus ();

  gv_button_conditioner #(
    .NUM_BTN         (4),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                           input logic [3:0] rel, input logic vld, input logic [1:0] idx);
    chk({tag, " level"},   {28'h0, bus.btn_level},   {28'h0, lvl});
    chk({tag, " press"},   {28'h0, bus.btn_press},   {28'h0, prs});
    chk({tag, " release"}, {28'h0, bus.btn_release}, {28'h0, rel});
    chk({tag, " valid"},   {31'h0, bus.press_valid}, {31'h0, vld});
    chk({tag, " idx"},     {30'h0, bus.press_idx},   {30'h0, idx});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_n(input int n, input logic r, input logic [3:0] raw, input logic [3:0] lvl,
                       input logic [3:0] prs, input logic [3:0] rel, input logic vld,
                       input logic [1:0] idx);
    vec_t v;
    v.n_rst = r; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.vld = vld; v.idx = idx;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_rst    = 1'b0;
    bus.btn_raw = 4'hF;

    // reset with pins high, then idle
    add_n(3, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
    add_n(2, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
    // clean press of button 2: level after edge 5
    add_n(5, 1'b1, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
    add_n(1, 1'b1, 4'h4, 4'h4, 4'h4, 4'h0, 1'b1, 2'd2);
    add_n(1, 1'b1, 4'h4, 4'h4, 4'h0, 4'h0, 1'b0, 2'd0);
    add_n(5, 1'b1, 4'h0, 4'h4, 4'h0, 4'h0, 1'b0, 2'd0);
    add_n(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h4, 1'b0, 2'd0);
    add_n(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
    // chord 1010
    add_n(5, 1'b1, 4'hA, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
    add_n(1, 1'b1, 4'hA, 4'hA, 4'hA, 4'h0, 1'b1, 2'd1);
    add_n(1, 1'b1, 4'hA, 4'hA, 4'h0, 4'h0, 1'b0, 2'd0);
    add_n(5, 1'b1, 4'h0, 4'hA, 4'h0, 4'h0, 1'b0, 2'd0);
    add_n(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'hA, 1'b0, 2'd0);
    add_n(1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);

    foreach (vecs[k]) begin
      n_rst       = vecs[k].n_rst;
      bus.btn_raw = vecs[k].raw;
      step();
      check_out($sformatf("vec%0d", k), vecs[k].lvl, vecs[k].prs, vecs[k].rel,
                vecs[k].vld, vecs[k].idx);
`ifndef GV_BTN_HOLD_EN
      chk($sformatf("vec%0d hold", k), {28'h0, bus.btn_hold}, 32'h0);
`endif
    end

    // bounce: high 3, low 1, for 20 cycles -> nothing accepted
    for (int n = 0; n < 20; n++) begin
      bus.btn_raw = ((n % 4) != 3) ? 4'h1 : 4'h0;
      step();
      check_out($sformatf("bounce%0d", n), 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
    end
    bus.btn_raw = 4'h1;
    for (int n = 0; n < 5; n++) begin
      step();
      check_out($sformatf("settle%0d", n), 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
    end
    step();
    check_out("bounce accept", 4'h1, 4'h1, 4'h0, 1'b1, 2'd0);
    step();
    check_out("bounce after", 4'h1, 4'h0, 4'h0, 1'b0, 2'd0);
    bus.btn_raw = 4'h0;
    for (int n = 0; n < 5; n++) step();
    step();
    check_out("bounce release", 4'h0, 4'h0, 4'h1, 1'b0, 2'd0);

    // reset while button 1 debounce counter sits at 2
    bus.btn_raw = 4'h2;
    for (int n = 0; n < 4; n++) step();
    n_rst = 1'b0;
    step();
    check_out("midrst", 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
    n_rst = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      check_out($sformatf("midrst restart%0d", n), 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
    end
    step();
    check_out("midrst accept", 4'h2, 4'h2, 4'h0, 1'b1, 2'd1);
    bus.btn_raw = 4'h0;
    for (int n = 0; n < 6; n++) step();
    check_out("midrst release", 4'h0, 4'h0, 4'h2, 1'b0, 2'd0);
    step();

    // long press on button 3
    bus.btn_raw = 4'h8;
    for (int n = 0; n < 5; n++) step();
    step();
    check_out("hold press", 4'h8, 4'h8, 4'h0, 1'b1, 2'd3);
    chk("hold at rise", {28'h0, bus.btn_hold}, 32'h0);
    for (int j = 1; j <= 10; j++) begin
      step();
      chk($sformatf("hold +%0d", j), {28'h0, bus.btn_hold},
          {28'h0, (j >= 8) ? HOLD_BIT : 4'h0});
    end
    bus.btn_raw = 4'h0;
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("hold rel%0d", n), {28'h0, bus.btn_hold}, {28'h0, HOLD_BIT});
    end
    step();
    check_out("hold release", 4'h0, 4'h0, 4'h8, 1'b0, 2'd0);
    chk("hold drop", {28'h0, bus.btn_hold}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
